mac_pipe: RTL
=============

MAC_PIPE -- requirements
Module: mac_pipe

Interface
REQ-001 Parameter IN_BITWIDTH, default 16, signed operand width.
REQ-002 Parameter OUT_BITWIDTH, default 2*IN_BITWIDTH, accumulator/result width.
REQ-003 Parameter LANES, default 4, multiply lanes summed per beat (dot product).
REQ-004 Parameter LEN_BITS, default 8, width of acc_len.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 a_in  input  LANES*IN_BITWIDTH  activations; lane k at bits [k*IN_BITWIDTH +: IN_BITWIDTH].
REQ-008 w_in  input  LANES*IN_BITWIDTH  weights, same packing.
REQ-009 sum_in  input  OUT_BITWIDTH  partial sum; used on first beat of a group only.
REQ-010 acc_len  input  LEN_BITS  beats per group; sampled on first beat.
REQ-011 in_valid / in_ready  input / output  1  input beat handshake.
REQ-012 out  output  OUT_BITWIDTH  accumulated result.
REQ-013 out_valid / out_ready  output / input  1  result handshake.
REQ-014 sat_flag  output  1  result saturated (see Configuration).

Function
REQ-015 Beat accepted when in_valid && in_ready at a rising edge.
REQ-016 All arithmetic two's-complement signed; products sign-extended to OUT_BITWIDTH before summing.
REQ-017 Stage 1: beat accepted at edge t registers LANES products at t+1.
REQ-018 Stage 2: adder tree sum of products added into accumulator at t+2.
REQ-019 First beat of a group: acc = sum_in + dot; later beats: acc = acc + dot.
REQ-020 acc_len == 0 treated as 1.
REQ-021 FSM states: IDLE, ACCUM, DRAIN, HOLD.
REQ-022 IDLE -> ACCUM on first accepted beat when effective length > 1; IDLE -> DRAIN when length == 1.
REQ-023 ACCUM -> DRAIN when the beat bringing the count to the effective length is accepted.
REQ-024 DRAIN -> HOLD when the last beat reaches the accumulator (t+2); out_valid rises that same edge.
REQ-025 HOLD -> IDLE on out_valid && out_ready; out and out_valid stay stable until then.
REQ-026 in_ready = 1 in IDLE and ACCUM, 0 in DRAIN and HOLD.
REQ-027 Back-to-back beats in ACCUM: one beat per cycle, no bubbles.
REQ-028 Group latency: out_valid asserts 2 cycles after the last beat is accepted.
REQ-029 in_valid low in ACCUM: pipeline stalls; count and acc hold.
REQ-030 Without saturation, accumulation wraps modulo 2^OUT_BITWIDTH.

Reset
REQ-031 reset asserted: state = IDLE, out = 0, out_valid = 0, sat_flag = 0, beat count = 0, pipeline valids = 0, accumulator = 0.
REQ-032 reset mid-group or in HOLD: partial result discarded, no output handshake; in_ready = 1 in the first cycle after deassertion.

Configuration
REQ-033 Macro MAC_PIPE_SAT_EN defined: each accumulator update clamps to [-2^(OUT_BITWIDTH-1), 2^(OUT_BITWIDTH-1)-1].
REQ-034 With MAC_PIPE_SAT_EN, any clamp sets sat_flag, sticky for the group; clears on the result handshake.
REQ-035 Macro undefined: wrap per REQ-030; sat_flag tied to 0.

Structure
REQ-036 Package mac_pkg holds the FSM state enum and sat min/max constant functions of OUT_BITWIDTH.
REQ-037 Sub-module mac_lane_mult: one registered signed multiplier; LANES instances form stage 1.

Verification
REQ-038 Reset, then one beat, acc_len=1, all lanes a=2 w=3, sum_in=10 -> out=34, out_valid 2 cycles after acceptance.
REQ-039 acc_len=4, back-to-back beats, lane0 a=1 w=1 rest 0, sum_in=5 -> out=9; in_ready 0 from DRAIN until handshake.
REQ-040 out_ready held low 5 cycles in HOLD -> out, out_valid stable; in_ready 0 throughout.
REQ-041 Signed: a=-3 w=7 lane0, acc_len=2 -> out=-42.
REQ-042 IN=16, 4 lanes a=w=32767, acc_len=255: with MAC_PIPE_SAT_EN -> out=2^31-1, sat_flag=1; without -> wrapped value, sat_flag=0.
REQ-043 reset asserted in ACCUM after 2 of 4 beats -> outputs 0, no out_valid; next group yields a correct result.

Source files
------------

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the mac_pipe dot-product accumulator:
//   - mac_state_e : controller state encoding (IDLE, ACCUM, DRAIN, HOLD)
//   - sat_max()   : largest signed value representable in out_w bits
//   - sat_min()   : smallest signed value representable in out_w bits
// The saturation helpers return a wide signed value so callers can size-cast
// them to whatever accumulator width they use.
// -----------------------------------------------------------------------------
package mac_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } mac_state_e;

   localparam int SAT_CALC_W = 128;

   function automatic logic signed [SAT_CALC_W-1:0] sat_max(input int out_w);
      return (SAT_CALC_W'(1) << (out_w - 1)) - SAT_CALC_W'(1);
   endfunction

   function automatic logic signed [SAT_CALC_W-1:0] sat_min(input int out_w);
      return -(SAT_CALC_W'(1) << (out_w - 1));
   endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// -----------------------------------------------------------------------------
// mac_lane_mult
// One registered signed multiplier lane. The product is sign-extended (or
// truncated) to OUT_BITWIDTH and captured when en_i is high; otherwise the
// register holds.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   en_i        : capture enable
//   a_i, w_i    : signed operands, IN_BITWIDTH each
//   prod_o      : registered product, OUT_BITWIDTH
// -----------------------------------------------------------------------------
module mac_lane_mult
   import mac_pkg::*;
#(
   parameter int IN_BITWIDTH  = 16,
   parameter int OUT_BITWIDTH = 2 * IN_BITWIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en_i,
   input  logic [IN_BITWIDTH-1:0]  a_i,
   input  logic [IN_BITWIDTH-1:0]  w_i,
   output logic [OUT_BITWIDTH-1:0] prod_o
);

   logic signed [2*IN_BITWIDTH-1:0] full_prod;
   logic [OUT_BITWIDTH-1:0]         prod_d;
   logic [OUT_BITWIDTH-1:0]         prod_q;

   // Operands are widened first so the multiply is done at full precision.
   assign full_prod = (2*IN_BITWIDTH)'(signed'(a_i)) * (2*IN_BITWIDTH)'(signed'(w_i));
   assign prod_d    = OUT_BITWIDTH'(full_prod);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod_q <= '0;
      end else if (en_i) begin
         prod_q <= prod_d;
      end
   end

   assign prod_o = prod_q;

endmodule

// File: rtl/mac_pipe.sv
// -----------------------------------------------------------------------------
// mac_pipe
// Pipelined LANES-wide signed dot-product accumulator. A group of acc_len beats
// (0 treated as 1) is summed on top of sum_in; the result is presented on out
// with a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE/ACCUM. out_valid, out and sat_flag
// stay stable while out_valid is high until out_ready is seen.
//
// Pipeline: edge t accepts the beat into input registers, edge t+1 registers
// the lane products, edge t+2 folds the adder-tree sum into the accumulator.
// out_valid rises on the same edge the last beat reaches the accumulator.
//
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   a_in, w_in           : LANES packed signed operands (lane k at k*IN_BITWIDTH)
//   sum_in               : partial sum, used on first beat of a group
//   acc_len              : beats per group, sampled on first beat
//   in_valid / in_ready  : input beat handshake
//   out                  : accumulated result
//   out_valid / out_ready: result handshake
//   sat_flag             : result saturated during this group
//
// Build option: define MAC_PIPE_SAT_EN to clamp each accumulator update to the
// signed OUT_BITWIDTH range and report it on sat_flag (sticky per group). When
// undefined the accumulator wraps and sat_flag is tied low.
// -----------------------------------------------------------------------------
module mac_pipe
   import mac_pkg::*;
#(
   parameter int IN_BITWIDTH  = 16,
   parameter int OUT_BITWIDTH = 2 * IN_BITWIDTH,
   parameter int LANES        = 4,
   parameter int LEN_BITS     = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [LANES*IN_BITWIDTH-1:0] a_in,
   input  logic [LANES*IN_BITWIDTH-1:0] w_in,
   input  logic [OUT_BITWIDTH-1:0]      sum_in,
   input  logic [LEN_BITS-1:0]          acc_len,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [OUT_BITWIDTH-1:0]      out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         sat_flag
);

`ifdef MAC_PIPE_SAT_EN
   // Headroom so the unclamped sum of base + LANES products cannot overflow.
   localparam int WW = OUT_BITWIDTH + LANES;
   localparam logic signed [WW-1:0] SAT_MAX_W = WW'(sat_max(OUT_BITWIDTH));
   localparam logic signed [WW-1:0] SAT_MIN_W = WW'(sat_min(OUT_BITWIDTH));
`else
   localparam int WW = OUT_BITWIDTH;
`endif

   mac_state_e state_q, state_d;
   logic [LEN_BITS-1:0] cnt_q, cnt_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic                last_beat;
   logic                accept;
   logic                out_hs;

   // Stage 0: captured input beat
   logic [LANES*IN_BITWIDTH-1:0] a_q, w_q;
   logic [OUT_BITWIDTH-1:0]      sum0_q;
   logic                         v0_q, first0_q, last0_q;
   // Stage 1: products registered in the lanes, control travels alongside
   logic [OUT_BITWIDTH-1:0]      prod [LANES];
   logic [OUT_BITWIDTH-1:0]      sum1_q;
   logic                         v1_q, first1_q, last1_q;
   // Stage 2: accumulator
   logic signed [WW-1:0]         acc_wide;
   logic [OUT_BITWIDTH-1:0]      acc_q, acc_d;
   logic                         out_valid_q;

   assign accept = in_valid && in_ready;
   assign out_hs = out_valid_q && out_ready;

   // ---------------- controller ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      last_beat = 1'b0;
      in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               len_d = (acc_len == '0) ? LEN_BITS'(1) : acc_len;
               cnt_d = LEN_BITS'(1);
               if (acc_len <= LEN_BITS'(1)) begin
                  last_beat = 1'b1;
                  state_d   = S_DRAIN;
               end else begin
                  state_d = S_ACCUM;
               end
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               cnt_d = cnt_q + LEN_BITS'(1);
               if (cnt_d == len_q) begin
                  last_beat = 1'b1;
                  state_d   = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (v1_q && last1_q) state_d = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- stage 0 / stage 1 control ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q      <= '0;
         w_q      <= '0;
         sum0_q   <= '0;
         v0_q     <= 1'b0;
         first0_q <= 1'b0;
         last0_q  <= 1'b0;
         sum1_q   <= '0;
         v1_q     <= 1'b0;
         first1_q <= 1'b0;
         last1_q  <= 1'b0;
      end else begin
         v0_q <= accept;
         if (accept) begin
            a_q      <= a_in;
            w_q      <= w_in;
            sum0_q   <= sum_in;
            first0_q <= (state_q == S_IDLE);
            last0_q  <= last_beat;
         end
         v1_q <= v0_q;
         if (v0_q) begin
            sum1_q   <= sum0_q;
            first1_q <= first0_q;
            last1_q  <= last0_q;
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      mac_lane_mult #(
         .IN_BITWIDTH (IN_BITWIDTH),
         .OUT_BITWIDTH(OUT_BITWIDTH)
      ) u_mult (
         .clk   (clk),
         .reset (reset),
         .en_i  (v0_q),
         .a_i   (a_q[k*IN_BITWIDTH +: IN_BITWIDTH]),
         .w_i   (w_q[k*IN_BITWIDTH +: IN_BITWIDTH]),
         .prod_o(prod[k])
      );
   end

   // ---------------- stage 2: adder tree + accumulate ----------------
`ifdef MAC_PIPE_SAT_EN
   logic clamp;
   logic sat_q;
`endif

   always_comb begin
      // First beat of a group starts from sum_in instead of the old result.
      acc_wide = first1_q ? WW'(signed'(sum1_q)) : WW'(signed'(acc_q));
      for (int k = 0; k < LANES; k++) begin
         acc_wide = acc_wide + WW'(signed'(prod[k]));
      end
`ifdef MAC_PIPE_SAT_EN
      clamp = 1'b0;
      acc_d = OUT_BITWIDTH'(acc_wide);
      if (acc_wide > SAT_MAX_W) begin
         acc_d = OUT_BITWIDTH'(SAT_MAX_W);
         clamp = 1'b1;
      end else if (acc_wide < SAT_MIN_W) begin
         acc_d = OUT_BITWIDTH'(SAT_MIN_W);
         clamp = 1'b1;
      end
`else
      acc_d = acc_wide;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (v1_q) acc_q <= acc_d;
         out_valid_q <= (state_d == S_HOLD);
      end
   end

`ifdef MAC_PIPE_SAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sat_q <= 1'b0;
      end else if (v1_q && clamp) begin
         sat_q <= 1'b1;
      end else if (out_hs) begin
         sat_q <= 1'b0;
      end
   end
   assign sat_flag = sat_q;
`else
   assign sat_flag = 1'b0;
`endif

   assign out       = acc_q;
   assign out_valid = out_valid_q;

endmodule
